// File: rtl/tournament_branch_predictor_if.sv
// Fetch/resolve bus of the tournament branch predictor: query, snapshots, training.
// Latency: prediction signals are combinational; training signals are consumed at the clock edge.
// Backpressure: none; the fetch side qualifies predictions and training is accepted every cycle.
//
// Signals:
//   pipeline_en, pred_pc, pred_is_br         fetch-side query (master -> slave)
//   pred_taken, pred_local, pred_global,     prediction and snapshots (slave -> master)
//   pred_ghr
//   upd_valid, upd_pc, upd_taken,            resolved-branch training (master -> slave)
//   upd_mispredict, upd_local, upd_global,
//   upd_ghr
interface tournament_branch_predictor_if #(
    parameter int GHR_BITS = 6
);
    logic                pipeline_en;
    logic [31:0]         pred_pc;
    logic                pred_is_br;
    logic                pred_taken;
    logic                pred_local;
    logic                pred_global;
    logic [GHR_BITS-1:0] pred_ghr;

    logic                upd_valid;
    logic [31:0]         upd_pc;
    logic                upd_taken;
    logic                upd_mispredict;
    logic                upd_local;
    logic                upd_global;
    logic [GHR_BITS-1:0] upd_ghr;

    modport master (
        output pipeline_en, pred_pc, pred_is_br,
        output upd_valid, upd_pc, upd_taken, upd_mispredict, upd_local, upd_global, upd_ghr,
        input  pred_taken, pred_local, pred_global, pred_ghr
    );

    modport slave (
        input  pipeline_en, pred_pc, pred_is_br,
        input  upd_valid, upd_pc, upd_taken, upd_mispredict, upd_local, upd_global, upd_ghr,
        output pred_taken, pred_local, pred_global, pred_ghr
    );
endinterface

// File: rtl/tournament_branch_predictor.sv
// Tournament direction predictor: two-level local + gshare global + per-PC chooser.
// Latency: zero-cycle combinational prediction; training and GHR updates take effect next cycle.
// Backpressure: none; one training update accepted per cycle regardless of pipeline_en.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bp (slave)        query/snapshot/training bus, see tournament_branch_predictor_if
//   stat_branches     (TOURNAMENT_PRED_STATS_EN only) saturating count of training updates
//   stat_mispredicts  (TOURNAMENT_PRED_STATS_EN only) saturating count of mispredict updates
// Optional feature macro: TOURNAMENT_PRED_STATS_EN
module tournament_branch_predictor #(
    parameter int LHT_IDX_BITS     = 5,
    parameter int LOCAL_HIST_BITS  = 4,
    parameter int GHR_BITS         = 6,
    parameter int CTR_BITS         = 2,
    parameter int CHOOSER_IDX_BITS = 5
) (
    input  logic clk,
    input  logic rst_n,
    tournament_branch_predictor_if.slave bp
`ifdef TOURNAMENT_PRED_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int LHT_N = 1 << LHT_IDX_BITS;
    localparam int LCT_N = 1 << LOCAL_HIST_BITS;
    localparam int GCT_N = 1 << GHR_BITS;
    localparam int CH_N  = 1 << CHOOSER_IDX_BITS;
    localparam int IDX_A = (LHT_IDX_BITS > GHR_BITS) ? LHT_IDX_BITS : GHR_BITS;
    localparam int IDX_MAX = (IDX_A > CHOOSER_IDX_BITS) ? IDX_A : CHOOSER_IDX_BITS;

    typedef logic [CTR_BITS-1:0] ctr_t;

    localparam ctr_t CTR_MAX  = '1;
    localparam ctr_t CTR_ONE  = ctr_t'(1);
    // Weakly not-taken / weakly local: MSB clear, all lower bits set.
    localparam ctr_t CTR_INIT = ctr_t'((1 << (CTR_BITS - 1)) - 1);

    logic [LOCAL_HIST_BITS-1:0] r_lht [LHT_N];
    ctr_t                       r_lct [LCT_N];
    ctr_t                       r_gct [GCT_N];
    ctr_t                       r_ch  [CH_N];
    logic [GHR_BITS-1:0]        r_ghr;

    logic [LHT_IDX_BITS-1:0]     w_pred_lht_idx;
    logic [LHT_IDX_BITS-1:0]     w_upd_lht_idx;
    logic [LOCAL_HIST_BITS-1:0]  w_pred_hist;
    logic [LOCAL_HIST_BITS-1:0]  w_upd_hist;
    logic [GHR_BITS-1:0]         w_pred_gidx;
    logic [GHR_BITS-1:0]         w_upd_gidx;
    logic [CHOOSER_IDX_BITS-1:0] w_pred_ch_idx;
    logic [CHOOSER_IDX_BITS-1:0] w_upd_ch_idx;
    logic                        w_pred_local;
    logic                        w_pred_global;
    logic                        w_pred_taken;
    logic                        w_recover;
    logic                        w_spec_shift;
    logic                        w_unused_pc;

    function automatic ctr_t ctr_move(input ctr_t c, input logic up);
        if (up) begin
            return (c == CTR_MAX) ? c : c + CTR_ONE;
        end
        return (c == '0) ? c : c - CTR_ONE;
    endfunction

    // ---------------- prediction (combinational, pre-update state) ----------------
    assign w_pred_lht_idx = bp.pred_pc[LHT_IDX_BITS+1:2];
    assign w_pred_hist    = r_lht[w_pred_lht_idx];
    assign w_pred_gidx    = bp.pred_pc[GHR_BITS+1:2] ^ r_ghr;
    assign w_pred_ch_idx  = bp.pred_pc[CHOOSER_IDX_BITS+1:2];

    assign w_pred_local  = r_lct[w_pred_hist][CTR_BITS-1];
    assign w_pred_global = r_gct[w_pred_gidx][CTR_BITS-1];
    assign w_pred_taken  = r_ch[w_pred_ch_idx][CTR_BITS-1] ? w_pred_global : w_pred_local;

    assign bp.pred_local  = w_pred_local;
    assign bp.pred_global = w_pred_global;
    assign bp.pred_taken  = w_pred_taken;
    assign bp.pred_ghr    = r_ghr;

    // ---------------- training indices ----------------
    assign w_upd_lht_idx = bp.upd_pc[LHT_IDX_BITS+1:2];
    assign w_upd_hist    = r_lht[w_upd_lht_idx];
    assign w_upd_gidx    = bp.upd_pc[GHR_BITS+1:2] ^ bp.upd_ghr;
    assign w_upd_ch_idx  = bp.upd_pc[CHOOSER_IDX_BITS+1:2];

    assign w_recover    = bp.upd_valid & bp.upd_mispredict;
    assign w_spec_shift = bp.pipeline_en & bp.pred_is_br;

    assign w_unused_pc = ^{bp.pred_pc[31:IDX_MAX+2], bp.pred_pc[1:0],
                           bp.upd_pc[31:IDX_MAX+2], bp.upd_pc[1:0]};

    // Recovery rebuilds history from the snapshot that went with the mispredicted
    // branch, so it overrides any speculative shift from the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ghr <= '0;
        end else if (w_recover) begin
            r_ghr <= {bp.upd_ghr[GHR_BITS-2:0], bp.upd_taken};
        end else if (w_spec_shift) begin
            r_ghr <= {r_ghr[GHR_BITS-2:0], w_pred_taken};
        end
    end

    // Local counter is indexed by the history as it stood before this outcome.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LHT_N; i++) r_lht[i] <= '0;
        end else if (bp.upd_valid) begin
            r_lht[w_upd_lht_idx] <= {w_upd_hist[LOCAL_HIST_BITS-2:0], bp.upd_taken};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LCT_N; i++) r_lct[i] <= CTR_INIT;
        end else if (bp.upd_valid) begin
            r_lct[w_upd_hist] <= ctr_move(r_lct[w_upd_hist], bp.upd_taken);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < GCT_N; i++) r_gct[i] <= CTR_INIT;
        end else if (bp.upd_valid) begin
            r_gct[w_upd_gidx] <= ctr_move(r_gct[w_upd_gidx], bp.upd_taken);
        end
    end

    // Chooser only learns when the components disagreed; toward global if global was right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH_N; i++) r_ch[i] <= CTR_INIT;
        end else if (bp.upd_valid && (bp.upd_local != bp.upd_global)) begin
            r_ch[w_upd_ch_idx] <= ctr_move(r_ch[w_upd_ch_idx], bp.upd_global == bp.upd_taken);
        end
    end

`ifdef TOURNAMENT_PRED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (bp.upd_valid && (stat_branches != 32'hFFFF_FFFF)) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (w_recover && (stat_mispredicts != 32'hFFFF_FFFF)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/tournament_branch_predictor.md
Name: tournament_branch_predictor

Overview:
Parametrised tournament direction predictor for the fetch stage. It has three parts:
- a two-level local predictor (per-PC history table feeding a local counter table);
- a gshare global predictor with a speculative global history register (GHR) and mispredict recovery;
- a per-PC chooser.

The fetch stage queries it combinationally each cycle. The resolving stage trains it one update per cycle, carrying back the snapshots returned at prediction time.

Parameters:
LHT_IDX_BITS, 5, log2 entries of the local history table, indexed by pc[LHT_IDX_BITS+1:2]
LOCAL_HIST_BITS, 4, bits of history per local history table entry; the local counter table has 2^LOCAL_HIST_BITS counters
GHR_BITS, 6, global history length; the global counter table has 2^GHR_BITS counters
CTR_BITS, 2, saturating counter width for local, global and chooser counters (legal range 2..4)
CHOOSER_IDX_BITS, 5, log2 chooser entries, indexed by pc[CHOOSER_IDX_BITS+1:2]

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pipeline_en  in  1  fetch advance; speculative GHR shifts only when high
pred_pc  in  32  address being fetched
pred_is_br  in  1  fetched instruction is a conditional branch
pred_taken  out  1  final predicted direction
pred_local  out  1  local component prediction (snapshot)
pred_global  out  1  global component prediction (snapshot)
pred_ghr  out  GHR_BITS  GHR value used for this prediction (snapshot)
upd_valid  in  1  resolved conditional branch present
upd_pc  in  32  PC of resolved branch
upd_taken  in  1  actual outcome
upd_mispredict  in  1  final prediction was wrong
upd_local  in  1  returned pred_local snapshot
upd_global  in  1  returned pred_global snapshot
upd_ghr  in  GHR_BITS  returned pred_ghr snapshot

Behaviour:
- Reset (async, rst_n low):
  - every counter = 2^(CTR_BITS-1)-1 (weakly not-taken);
  - chooser counters = same value (weakly local);
  - all local history table entries = 0; GHR = 0.
  - The outputs are combinational, so while in reset: pred_taken=0, pred_local=0, pred_global=0, pred_ghr=0.
  - Reset during an update discards that update.
- Counter semantics: MSB=1 means taken (or global, for the chooser). Counters saturate at 0 and at 2^CTR_BITS-1 with no wrap.
- Prediction is combinational from current state, zero latency:
  - local: lht[pc idx] indexes the local counter table; pred_local = MSB.
  - global: index = pc[GHR_BITS+1:2] XOR GHR; pred_global = MSB.
  - pred_taken = chooser MSB ? pred_global : pred_local.
  - Outputs are valid regardless of pred_is_br; the consumer qualifies them.
- Speculative GHR: at posedge, if pipeline_en & pred_is_br & !(upd_valid & upd_mispredict), then GHR <= {GHR[GHR_BITS-2:0], pred_taken}.
- Update, applied at posedge when upd_valid:
  - Global counter at (upd_pc[GHR_BITS+1:2] XOR upd_ghr) moves toward upd_taken.
  - Local counter at the current lht[upd_pc idx] moves toward upd_taken.
  - lht[upd_pc idx] then shifts in upd_taken, so the new history is visible next cycle.
  - Chooser at the upd_pc idx is updated only when upd_local != upd_global: increment if upd_global==upd_taken, else decrement.
- Recovery: if upd_valid & upd_mispredict, GHR <= {upd_ghr[GHR_BITS-2:0], upd_taken}. This has priority over the speculative shift in the same cycle, irrespective of pipeline_en.
- Same-cycle read/write of the same entry: the prediction sees the pre-update value. There is no bypass.
- Updates ignore pipeline_en; a stalled fetch never blocks training.
- upd_mispredict without upd_valid is ignored.

Optional Feature:
Macro: TOURNAMENT_PRED_STATS_EN.
- When defined, adds two outputs:
  - stat_branches out 32: count of upd_valid cycles;
  - stat_mispredicts out 32: count of upd_valid & upd_mispredict cycles.
- Both counters saturate at 32'hFFFF_FFFF and reset to 0 on rst_n.
- When not defined, these ports and their counters do not exist, and prediction behaviour is identical.

Test Plan:
1. Reset, then query pred_pc=0x100 with pred_is_br=1 -> pred_taken=0, pred_local=0, pred_global=0, pred_ghr=6'h00.
2. Predict a branch with pipeline_en=1 three times, each predicted not-taken -> GHR stays 0. Hold pipeline_en=0 -> GHR unchanged.
3. Four upd_valid updates at upd_pc=0x100, upd_taken=1, upd_ghr=0, upd_local=upd_global=0 -> global counter at index 0x00 reaches 3. The chooser is untouched because the two snapshots agree.
4. Loop pattern at pc 0x200 (T,T,T,N repeated), fed back via snapshots -> pred_local matches the outcome on every branch after 4 warm-up periods.
5. GHR=6'b101010 with upd_mispredict=1, upd_ghr=6'b000111, upd_taken=1, and a simultaneous pred_is_br=1 with pipeline_en=1 -> next GHR=6'b001111 (recovery wins).
6. Repeated updates with upd_local=1, upd_global=0, upd_taken=0 -> chooser saturates toward global, pred_taken follows pred_global. Opposite pattern -> chooser returns to local. Under TOURNAMENT_PRED_STATS_EN, 10 updates with 3 mispredicts -> stat_branches=10, stat_mispredicts=3.
